acoustic_trigger: RTL and testbench

N-channel threshold trigger and windowed peak tracker for the acoustic front end. Takes filtered signed ADC samples from N_CH channels, arms after a holdoff, fires a start level to the correlator when any enabled channel exceeds a threshold, and waits for the correlator's done with a timeout. In parallel it reports each channel's positive peak value and its sample index over fixed windows.

---
 rtl/acoustic_pkg.sv | 21 ++
 rtl/acoustic_trigger_if.sv | 36 +++
 rtl/peak_tracker.sv | 54 +++++
 rtl/acoustic_trigger.sv | 148 ++++++++++++++
 tb/tb_acoustic_trigger.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acoustic_pkg.sv
// Shared definitions for the acoustic front end.
//   trig_state_t - trigger FSM state encoding
//   DATA_W_DEF   - default signed sample width
//   CNT_W_DEF    - default width of window/holdoff/timeout counters
//   idx_w()      - width of a channel index, never below one bit
package acoustic_pkg;

   typedef enum logic [1:0] {
      HOLDOFF   = 2'd0,
      ARMED     = 2'd1,
      TRIGGERED = 2'd2
   } trig_state_t;

   localparam int DATA_W_DEF = 12;
   localparam int CNT_W_DEF  = 21;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/acoustic_trigger_if.sv
// Sample/handshake/result bundle between the ADC front end, the trigger and
// the correlator.
//   master : drives samples, threshold, ch_enable, done; receives results
//   slave  : acoustic_trigger side
interface acoustic_trigger_if #(
   parameter int N_CH   = 4,
   parameter int DATA_W = acoustic_pkg::DATA_W_DEF,
   parameter int CNT_W  = acoustic_pkg::CNT_W_DEF
);
   import acoustic_pkg::*;

   localparam int CH_W = idx_w(N_CH);

   logic                     sample_valid;
   logic [N_CH*DATA_W-1:0]   samples;
   logic [DATA_W-1:0]        threshold;
   logic [N_CH-1:0]          ch_enable;
   logic                     done;
   logic                     start;
   logic [CH_W-1:0]          trig_ch;
   logic                     timeout;
   logic [N_CH*DATA_W-1:0]   peak_val;
   logic [N_CH*CNT_W-1:0]    peak_idx;
   logic                     win_valid;

   modport master (
      output sample_valid, samples, threshold, ch_enable, done,
      input  start, trig_ch, timeout, peak_val, peak_idx, win_valid
   );

   modport slave (
      input  sample_valid, samples, threshold, ch_enable, done,
      output start, trig_ch, timeout, peak_val, peak_idx, win_valid
   );

endinterface

// File: rtl/peak_tracker.sv
// Per-channel positive peak tracker over one window.
//   valid    - sample qualifier
//   last     - this valid sample closes the window
//   sample   - signed sample
//   idx      - window index of the current sample
//   peak_val - max of the last completed window (0 if nothing positive)
//   peak_idx - index of the first occurrence of that max
module peak_tracker import acoustic_pkg::*; #(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              AD9226_CLK,
   input  logic              reset_n,
   input  logic              valid,
   input  logic              last,
   input  logic [DATA_W-1:0] sample,
   input  logic [CNT_W-1:0]  idx,
   output logic [DATA_W-1:0] peak_val,
   output logic [CNT_W-1:0]  peak_idx
);

   logic [DATA_W-1:0] run_max;
   logic [CNT_W-1:0]  run_idx;
   logic [DATA_W-1:0] nxt_max;
   logic [CNT_W-1:0]  nxt_idx;
   logic              take;

   // Strict compare keeps the first occurrence; starting at 0 drops negatives.
   always_comb begin
      take    = $signed(sample) > $signed(run_max);
      nxt_max = take ? sample : run_max;
      nxt_idx = take ? idx : run_idx;
   end

   always_ff @(posedge AD9226_CLK or negedge reset_n) begin
      if (!reset_n) begin
         run_max  <= '0;
         run_idx  <= '0;
         peak_val <= '0;
         peak_idx <= '0;
      end else if (valid) begin
         if (last) begin
            peak_val <= nxt_max;
            peak_idx <= nxt_idx;
            run_max  <= '0;
            run_idx  <= '0;
         end else begin
            run_max  <= nxt_max;
            run_idx  <= nxt_idx;
         end
      end
   end

endmodule

// File: rtl/acoustic_trigger.sv
// N-channel threshold trigger with correlator handshake/timeout, plus
// free-running windowed positive peak reporting per channel.
//   AD9226_CLK - sample clock
//   reset_n    - asynchronous active-low reset
//   bus        - sample inputs, start/done handshake, trigger and peak results
//
// state     | meaning
// ----------+--------------------------------------------------------------
// HOLDOFF   | counting HOLDOFF valid samples, crossings ignored
// ARMED     | waiting for an enabled channel to exceed threshold
// TRIGGERED | start high, waiting for done or TIMEOUT cycles
module acoustic_trigger #(
   parameter int N_CH    = 4,
   parameter int DATA_W  = acoustic_pkg::DATA_W_DEF,
   parameter int CNT_W   = acoustic_pkg::CNT_W_DEF,
   parameter int HOLDOFF = 625_000,
   parameter int WIN_LEN = 1_291_666,
   parameter int TIMEOUT = 1_048_575
) (
   input logic               AD9226_CLK,
   input logic               reset_n,
   acoustic_trigger_if.slave bus
);
   import acoustic_pkg::*;

   localparam int CH_W = idx_w(N_CH);

   trig_state_t            state;
   logic [CNT_W-1:0]       fsm_cnt;
   logic [CNT_W-1:0]       win_cnt;
   logic                   start_r;
   logic                   timeout_r;
   logic                   win_valid_r;
   logic [CH_W-1:0]        trig_ch_r;
   logic [N_CH-1:0]        over;
   logic                   hit;
   logic [CH_W-1:0]        hit_ch;
   logic                   win_last;
   logic [N_CH*DATA_W-1:0] peak_val_w;
   logic [N_CH*CNT_W-1:0]  peak_idx_w;

   always_comb begin
      over = '0;
      for (int k = 0; k < N_CH; k++) begin
         over[k] = bus.ch_enable[k] &&
                   ($signed(bus.samples[k*DATA_W +: DATA_W]) > $signed(bus.threshold));
      end
   end

   // Scan downward so the lowest firing channel wins.
   always_comb begin
      hit_ch = '0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (over[k]) hit_ch = CH_W'(k);
      end
      hit = |over;
   end

   always_ff @(posedge AD9226_CLK or negedge reset_n) begin
      if (!reset_n) begin
         state     <= acoustic_pkg::HOLDOFF;
         fsm_cnt   <= '0;
         start_r   <= 1'b0;
         timeout_r <= 1'b0;
         trig_ch_r <= '0;
      end else begin
         timeout_r <= 1'b0;
         case (state)
            acoustic_pkg::HOLDOFF: begin
               if (bus.sample_valid) begin
                  if (fsm_cnt == CNT_W'(HOLDOFF - 1)) begin
                     fsm_cnt <= '0;
                     state   <= acoustic_pkg::ARMED;
                  end else begin
                     fsm_cnt <= fsm_cnt + CNT_W'(1);
                  end
               end
            end
            acoustic_pkg::ARMED: begin
               if (bus.sample_valid && hit) begin
                  state     <= acoustic_pkg::TRIGGERED;
                  start_r   <= 1'b1;
                  trig_ch_r <= hit_ch;
                  fsm_cnt   <= '0;
               end
            end
            acoustic_pkg::TRIGGERED: begin
               // done has priority over an expiring timeout on the same cycle.
               if (bus.done) begin
                  state   <= acoustic_pkg::HOLDOFF;
                  start_r <= 1'b0;
                  fsm_cnt <= '0;
               end else if (fsm_cnt == CNT_W'(TIMEOUT - 1)) begin
                  state     <= acoustic_pkg::HOLDOFF;
                  start_r   <= 1'b0;
                  timeout_r <= 1'b1;
                  fsm_cnt   <= '0;
               end else begin
                  fsm_cnt <= fsm_cnt + CNT_W'(1);
               end
            end
            default: begin
               state   <= acoustic_pkg::HOLDOFF;
               start_r <= 1'b0;
               fsm_cnt <= '0;
            end
         endcase
      end
   end

   assign win_last = bus.sample_valid && (win_cnt == CNT_W'(WIN_LEN - 1));

   always_ff @(posedge AD9226_CLK or negedge reset_n) begin
      if (!reset_n) begin
         win_cnt     <= '0;
         win_valid_r <= 1'b0;
      end else begin
         win_valid_r <= win_last;
         if (bus.sample_valid) begin
            win_cnt <= win_last ? '0 : win_cnt + CNT_W'(1);
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      peak_tracker #(
         .DATA_W (DATA_W),
         .CNT_W  (CNT_W)
      ) u_peak (
         .AD9226_CLK (AD9226_CLK),
         .reset_n    (reset_n),
         .valid      (bus.sample_valid),
         .last       (win_last),
         .sample     (bus.samples[k*DATA_W +: DATA_W]),
         .idx        (win_cnt),
         .peak_val   (peak_val_w[k*DATA_W +: DATA_W]),
         .peak_idx   (peak_idx_w[k*CNT_W +: CNT_W])
      );
   end

   assign bus.start     = start_r;
   assign bus.trig_ch   = trig_ch_r;
   assign bus.timeout   = timeout_r;
   assign bus.win_valid = win_valid_r;
   assign bus.peak_val  = peak_val_w;
   assign bus.peak_idx  = peak_idx_w;

endmodule

// File: tb/tb_acoustic_trigger.sv
// Bench for acoustic_trigger with N_CH=2, HOLDOFF=8, WIN_LEN=16, TIMEOUT=32,
// threshold=5. Window results are predicted by a reference model and queued;
// a monitor pops them when win_valid pulses.
module tb_acoustic_trigger;

   localparam int N_CH   = 2;
   localparam int DW     = 12;
   localparam int CW     = 21;
   localparam int WIN    = 16;

   typedef struct {
      int v0;
      int i0;
      int v1;
      int i1;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   int   m_idx;
   int   m_max[2];
   int   m_midx[2];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   acoustic_trigger_if #(.N_CH(N_CH), .DATA_W(DW), .CNT_W(CW)) bus ();

   acoustic_trigger #(
      .N_CH(N_CH), .DATA_W(DW), .CNT_W(CW),
      .HOLDOFF(8), .WIN_LEN(WIN), .TIMEOUT(32)
   ) dut (
      .AD9226_CLK (clk),
      .reset_n    (rst_n),
      .bus        (bus)
   );

   function automatic int pv(input int ch);
      logic [DW-1:0] v;
      v = bus.peak_val[ch*DW +: DW];
      return int'($signed(v));
   endfunction

   function automatic int pi(input int ch);
      return int'(bus.peak_idx[ch*CW +: CW]);
   endfunction

   task automatic model_clear();
      m_idx = 0;
      for (int c = 0; c < 2; c++) begin
         m_max[c]  = 0;
         m_midx[c] = 0;
      end
   endtask

   task automatic model_update(input int s0, input int s1);
      int   s[2];
      exp_t e;
      s[0] = s0;
      s[1] = s1;
      for (int c = 0; c < 2; c++) begin
         if (s[c] > m_max[c]) begin
            m_max[c]  = s[c];
            m_midx[c] = m_idx;
         end
      end
      if (m_idx == WIN - 1) begin
         e.v0 = m_max[0]; e.i0 = m_midx[0];
         e.v1 = m_max[1]; e.i1 = m_midx[1];
         sb_q.push_back(e);
         model_clear();
      end else begin
         m_idx++;
      end
   endtask

   task automatic step(input logic v, input int s0, input int s1, input logic d);
      bus.sample_valid = v;
      bus.samples      = {12'(s1), 12'(s0)};
      bus.done         = d;
      @(posedge clk);
      if (v && rst_n) model_update(s0, s1);
      #1;
      bus.sample_valid = 1'b0;
      bus.done         = 1'b0;
   endtask

   task automatic holdoff8();
      repeat (8) step(1'b1, 0, 0, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && bus.win_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_window: win_valid with nothing queued");
         end else begin
            e = sb_q.pop_front();
            if (pv(0) !== e.v0 || pi(0) !== e.i0 || pv(1) !== e.v1 || pi(1) !== e.i1) begin
               errors++;
               $display("FAIL sb_window: got ch0 %0d@%0d ch1 %0d@%0d, want ch0 %0d@%0d ch1 %0d@%0d",
                        pv(0), pi(0), pv(1), pi(1), e.v0, e.i0, e.v1, e.i1);
            end
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   task automatic test_reset();
      rst_n            = 1'b0;
      bus.sample_valid = 1'b0;
      bus.samples      = '0;
      bus.threshold    = 12'd5;
      bus.ch_enable    = 2'b11;
      bus.done         = 1'b0;
      model_clear();
      #3;
      checks++;
      if ({bus.start, bus.trig_ch, bus.timeout, bus.win_valid} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got start=%b trig_ch=%b timeout=%b win_valid=%b want all 0",
                  bus.start, bus.trig_ch, bus.timeout, bus.win_valid);
      end
      checks++;
      if (bus.peak_val !== '0 || bus.peak_idx !== '0) begin
         errors++;
         $display("FAIL reset_peaks: got val=%h idx=%h want 0", bus.peak_val, bus.peak_idx);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_holdoff();
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 100, 0, 1'b0);
         checks++;
         if (bus.start !== 1'b0) begin
            errors++;
            $display("FAIL holdoff_start sample %0d: got %b want 0", i + 1, bus.start);
         end
      end
      step(1'b1, 3, 0, 1'b0);
      checks++;
      if (bus.start !== 1'b0) begin
         errors++;
         $display("FAIL armed_below_threshold: start got %b want 0", bus.start);
      end
      step(1'b1, 6, 0, 1'b0);
      checks++;
      if (bus.start !== 1'b1 || bus.trig_ch !== 1'b0) begin
         errors++;
         $display("FAIL first_trigger: got start=%b trig_ch=%0d want start=1 trig_ch=0",
                  bus.start, bus.trig_ch);
      end
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 0, 0, 1'b0);
         checks++;
         if (bus.start !== 1'b1) begin
            errors++;
            $display("FAIL start_held cycle %0d: got %b want 1", i + 1, bus.start);
         end
      end
      step(1'b0, 0, 0, 1'b1);
      checks++;
      if (bus.start !== 1'b0) begin
         errors++;
         $display("FAIL start_fall_on_done: got %b want 0", bus.start);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 50, 0, 1'b0);
         checks++;
         if (bus.start !== 1'b0) begin
            errors++;
            $display("FAIL rearm_holdoff sample %0d: got %b want 0", i + 1, bus.start);
         end
      end
      step(1'b1, 50, 0, 1'b0);
      checks++;
      if (bus.start !== 1'b1) begin
         errors++;
         $display("FAIL retrigger_after_holdoff: got %b want 1", bus.start);
      end
      step(1'b0, 0, 0, 1'b1);
   endtask

   task automatic test_simultaneous();
      holdoff8();
      step(1'b1, 7, 9, 1'b0);
      checks++;
      if (bus.start !== 1'b1 || bus.trig_ch !== 1'b0) begin
         errors++;
         $display("FAIL simul_both_en: got start=%b trig_ch=%0d want 1/0", bus.start, bus.trig_ch);
      end
      step(1'b0, 0, 0, 1'b1);
      holdoff8();
      bus.ch_enable = 2'b10;
      step(1'b1, 7, 9, 1'b0);
      checks++;
      if (bus.start !== 1'b1 || bus.trig_ch !== 1'b1) begin
         errors++;
         $display("FAIL simul_ch1_only: got start=%b trig_ch=%0d want 1/1", bus.start, bus.trig_ch);
      end
      step(1'b0, 0, 0, 1'b1);
      holdoff8();
      bus.ch_enable = 2'b00;
      for (int i = 0; i < 4; i++) step(1'b1, 50, 50, 1'b0);
      step(1'b1, 0, 0, 1'b1);
      checks++;
      if (bus.start !== 1'b0) begin
         errors++;
         $display("FAIL no_enable_armed: start got %b want 0", bus.start);
      end
      bus.ch_enable = 2'b01;
      step(1'b1, 50, 0, 1'b0);
      checks++;
      if (bus.start !== 1'b1 || bus.trig_ch !== 1'b0) begin
         errors++;
         $display("FAIL enable_after_idle: got start=%b trig_ch=%0d want 1/0", bus.start, bus.trig_ch);
      end
   endtask

   task automatic test_timeout();
      for (int i = 1; i <= 32; i++) begin
         step(1'b0, 0, 0, 1'b0);
         checks++;
         if (bus.timeout !== (i == 32) || bus.start !== (i != 32)) begin
            errors++;
            $display("FAIL timeout_cycle %0d: got timeout=%b start=%b want %b/%b",
                     i, bus.timeout, bus.start, (i == 32), (i != 32));
         end
      end
      step(1'b0, 0, 0, 1'b0);
      checks++;
      if (bus.timeout !== 1'b0) begin
         errors++;
         $display("FAIL timeout_one_cycle: got %b want 0", bus.timeout);
      end
      holdoff8();
      step(1'b1, 50, 0, 1'b0);
      for (int i = 0; i < 31; i++) step(1'b0, 0, 0, 1'b0);
      step(1'b0, 0, 0, 1'b1);
      checks++;
      if (bus.timeout !== 1'b0 || bus.start !== 1'b0) begin
         errors++;
         $display("FAIL done_beats_timeout: got timeout=%b start=%b want 0/0", bus.timeout, bus.start);
      end
   endtask

   task automatic test_peaks();
      int ch1_a[16];
      ch1_a = '{0, 3, 9, 2, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      bus.ch_enable = 2'b00;
      while (m_idx != 0) step(1'b1, 0, 0, 1'b0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, -(i + 1), ch1_a[i], 1'b0);
         if (i == 14) begin
            checks++;
            if (bus.win_valid !== 1'b0) begin
               errors++;
               $display("FAIL win_valid_early: got %b want 0", bus.win_valid);
            end
         end
      end
      checks++;
      if (bus.win_valid !== 1'b1 || pv(1) !== 9 || pi(1) !== 2 || pv(0) !== 0 || pi(0) !== 0) begin
         errors++;
         $display("FAIL peaks_window_a: got wv=%b ch0 %0d@%0d ch1 %0d@%0d want 1 ch0 0@0 ch1 9@2",
                  bus.win_valid, pv(0), pi(0), pv(1), pi(1));
      end
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i == 15) ? 20 : i, (i == 4 || i == 9) ? 7 : 1, 1'b0);
      end
      checks++;
      if (bus.win_valid !== 1'b1 || pv(0) !== 20 || pi(0) !== 15 || pv(1) !== 7 || pi(1) !== 4) begin
         errors++;
         $display("FAIL peaks_window_b: got wv=%b ch0 %0d@%0d ch1 %0d@%0d want 1 ch0 20@15 ch1 7@4",
                  bus.win_valid, pv(0), pi(0), pv(1), pi(1));
      end
      step(1'b0, 0, 0, 1'b0);
      checks++;
      if (bus.win_valid !== 1'b0) begin
         errors++;
         $display("FAIL win_valid_pulse: got %b want 0", bus.win_valid);
      end
   endtask

   task automatic test_reset_mid();
      while (m_idx != 9) step(1'b1, 0, 0, 1'b0);
      bus.ch_enable = 2'b10;
      step(1'b1, 0, 30, 1'b0);
      checks++;
      if (bus.start !== 1'b1 || bus.trig_ch !== 1'b1 || m_idx != 10) begin
         errors++;
         $display("FAIL pre_reset_trigger: got start=%b trig_ch=%0d idx=%0d want 1/1/10",
                  bus.start, bus.trig_ch, m_idx);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.start, bus.trig_ch, bus.timeout, bus.win_valid} !== 4'b0 ||
          bus.peak_val !== '0 || bus.peak_idx !== '0) begin
         errors++;
         $display("FAIL async_reset: got start=%b trig_ch=%b val=%h idx=%h want all 0",
                  bus.start, bus.trig_ch, bus.peak_val, bus.peak_idx);
      end
      model_clear();
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      bus.ch_enable = 2'b01;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i < 9) ? 50 : 0, 0, 1'b0);
         if (i <= 8) begin
            checks++;
            if (bus.start !== (i == 8)) begin
               errors++;
               $display("FAIL post_reset_holdoff sample %0d: got start=%b want %b",
                        i + 1, bus.start, (i == 8));
            end
         end
         if (i == 14) begin
            checks++;
            if (bus.win_valid !== 1'b0) begin
               errors++;
               $display("FAIL post_reset_win_early: got %b want 0", bus.win_valid);
            end
         end
      end
      checks++;
      if (bus.win_valid !== 1'b1 || pv(0) !== 50 || pi(0) !== 0 || pv(1) !== 0 || pi(1) !== 0) begin
         errors++;
         $display("FAIL post_reset_window: got wv=%b ch0 %0d@%0d ch1 %0d@%0d want 1 ch0 50@0 ch1 0@0",
                  bus.win_valid, pv(0), pi(0), pv(1), pi(1));
      end
      step(1'b0, 0, 0, 1'b1);
   endtask

   initial begin
      test_reset();
      test_holdoff();
      test_handshake();
      test_simultaneous();
      test_timeout();
      test_peaks();
      test_reset_mid();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d windows pending want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
